// File: rtl/keypad_digit_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module : keypad_digit_collector_pkg
// Brief  : Shared types and sentinels for the keypad entry path: the
//          senhaPac_t packet type, special key codes, packet sentinels and
//          the collector state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package keypad_digit_collector_pkg;

   // Packet length in BCD digits; every consumer of senhaPac_t assumes 20.
   localparam int PAC_DIGITS = 20;
   localparam int PAC_WIDTH  = 4 * PAC_DIGITS;

   typedef logic [PAC_WIDTH-1:0] senhaPac_t;

   localparam logic [3:0] KEY_CONFIRM = 4'hA;   // '*'
   localparam logic [3:0] KEY_CLEAR   = 4'hB;   // '#'

   localparam senhaPac_t PAC_EMPTY = {PAC_DIGITS{4'hF}};
   localparam senhaPac_t PAC_EXIT  = {PAC_DIGITS{4'hB}};
   localparam senhaPac_t PAC_VOID  = {PAC_DIGITS{4'hE}};

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_EMPTY  = 2'd1,
      ST_TYPING = 2'd2,
      ST_SEND   = 2'd3
   } collector_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_digit_collector_inactivity_timer.sv
`default_nettype none
// ============================================================================
// Module : inactivity_timer
// Brief  : Saturating idle counter. Counts cycles while run is high and
//          flags expired once TIMEOUT_CYCLES-1 is reached; holds there
//          until cleared. Shared with the lock auto-relock logic.
// Ports  : clk, rst (sync, active-high)
//          clear   - restart count at zero (wins over run)
//          run     - advance one per cycle
//          expired - count has reached TIMEOUT_CYCLES-1
// Rev    : 1.0  initial release
// ============================================================================
module inactivity_timer #(
   parameter int TIMEOUT_CYCLES = 250_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && (count != LIMIT)) begin
         // Stop at LIMIT so a stalled consumer never sees the count wrap.
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/keypad_digit_collector.sv
`default_nettype none
// ============================================================================
// Module : keypad_digit_collector
// Brief  : Collects debounced keypad events into senhaPac_t packets. Echoes
//          the partial entry live and emits one-cycle packets on confirm,
//          exit and inactivity timeout.
// Ports  : clk, rst (sync, active-high)
//          enable        - collector active; low discards the entry
//          key_valid     - one-cycle pulse per key press
//          key_code      - 0-9 digit, A confirm, B clear/exit, C-F ignored
//          digitos_value - packet / live echo, digit[0] = most recent key
//          digitos_valid - one-cycle packet strobe
//          digit_count   - digits currently buffered
// Rev    : 1.0  initial release
// ============================================================================
module keypad_digit_collector
   import keypad_digit_collector_pkg::*;
#(
   parameter int MAX_DIGITS     = 20,
   parameter int TIMEOUT_CYCLES = 250_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    key_valid,
   input  logic [3:0]              key_code,
   output logic [4*MAX_DIGITS-1:0] digitos_value,
   output logic                    digitos_valid,
   output logic [4:0]              digit_count
);

   collector_state_t        state, state_n;
   logic [4*MAX_DIGITS-1:0] shift_buf, shift_buf_n;
   logic [4:0]              count_n;
   logic [4*MAX_DIGITS-1:0] pkt_n;
   logic                    load_pkt;

   logic key_digit, key_confirm, key_clear, key_accepted;
   logic timer_clear, timer_run, timer_expired;

   assign key_digit    = key_valid && is_digit(key_code);
   assign key_confirm  = key_valid && (key_code == KEY_CONFIRM);
   assign key_clear    = key_valid && (key_code == KEY_CLEAR);
   assign key_accepted = key_digit || key_confirm || key_clear;

   // Holding the timer cleared outside TYPING guarantees it starts from zero
   // on every fresh entry.
   assign timer_run   = (state == ST_TYPING);
   assign timer_clear = (state != ST_TYPING) || key_accepted;

   inactivity_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .run     (timer_run),
      .expired (timer_expired)
   );

   always_comb begin
      state_n     = state;
      shift_buf_n = shift_buf;
      count_n     = digit_count;
      pkt_n       = PAC_EMPTY;
      load_pkt    = 1'b0;

      unique case (state)
         ST_OFF: begin
            shift_buf_n = PAC_EMPTY;
            count_n     = 5'd0;
            state_n     = ST_EMPTY;
         end

         ST_EMPTY: begin
            if (key_digit) begin
               shift_buf_n = {shift_buf[4*MAX_DIGITS-5:0], key_code};
               count_n     = 5'd1;
               state_n     = ST_TYPING;
            end else if (key_confirm) begin
               pkt_n    = PAC_EMPTY;
               load_pkt = 1'b1;
               state_n  = ST_SEND;
            end else if (key_clear) begin
               pkt_n    = PAC_EXIT;
               load_pkt = 1'b1;
               state_n  = ST_SEND;
            end
         end

         ST_TYPING: begin
            // Any accepted key takes priority over a coincident timeout.
            if (key_digit) begin
               if (digit_count < 5'(MAX_DIGITS)) begin
                  shift_buf_n = {shift_buf[4*MAX_DIGITS-5:0], key_code};
                  count_n     = digit_count + 5'd1;
               end
            end else if (key_confirm) begin
               pkt_n       = shift_buf;
               load_pkt    = 1'b1;
               shift_buf_n = PAC_EMPTY;
               state_n     = ST_SEND;
            end else if (key_clear) begin
               shift_buf_n = PAC_EMPTY;
               count_n     = 5'd0;
               state_n     = ST_EMPTY;
            end else if (timer_expired) begin
               pkt_n       = PAC_VOID;
               load_pkt    = 1'b1;
               shift_buf_n = PAC_EMPTY;
               state_n     = ST_SEND;
            end
         end

         ST_SEND: begin
            shift_buf_n = PAC_EMPTY;
            count_n     = 5'd0;
            state_n     = ST_EMPTY;
         end

         default: begin
            state_n = ST_OFF;
         end
      endcase

      // Disable overrides everything, including a packet about to go out.
      if (!enable) begin
         state_n     = ST_OFF;
         shift_buf_n = PAC_EMPTY;
         count_n     = 5'd0;
         load_pkt    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_OFF;
         shift_buf     <= PAC_EMPTY;
         digit_count   <= 5'd0;
         digitos_value <= PAC_EMPTY;
         digitos_valid <= 1'b0;
      end else begin
         state         <= state_n;
         shift_buf     <= shift_buf_n;
         digit_count   <= count_n;
         // The packet occupies the output for the SEND cycle only; otherwise
         // the output mirrors the buffer as the live echo.
         digitos_value <= load_pkt ? pkt_n : shift_buf_n;
         digitos_valid <= load_pkt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_digit_collector
// Brief  : Self-checking bench for keypad_digit_collector with a queue-based
//          reference model of the entry rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_keypad_digit_collector;
   import keypad_digit_collector_pkg::*;

   localparam int T = 16;
   localparam logic [79:0] ALL_F = {20{4'hF}};
   localparam logic [79:0] EXITP = {20{4'hB}};
   localparam logic [79:0] VOIDP = {20{4'hE}};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic [79:0] digitos_value;
   logic        digitos_valid;
   logic [4:0]  digit_count;

   always #5 clk = ~clk;

   keypad_digit_collector #(
      .MAX_DIGITS     (20),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .digitos_value (digitos_value),
      .digitos_valid (digitos_valid),
      .digit_count   (digit_count)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase 0 = off, 1 = collecting, 2 = packet just sent.
   int          m_phase = 0;
   int          q[$];
   int          idle = 0;
   logic [79:0] m_value = ALL_F;
   logic        m_valid = 1'b0;
   int          m_count = 0;

   function automatic logic [79:0] pack_q();
      logic [79:0] p;
      p = ALL_F;
      for (int i = 0; i < q.size(); i++) p[4*i +: 4] = 4'(q[q.size()-1-i]);
      return p;
   endfunction

   task automatic emit(input logic [79:0] pkt);
      m_valid = 1'b1;
      m_value = pkt;
      q.delete();
      idle    = 0;
      m_phase = 2;
   endtask

   task automatic model_edge(input logic r, input logic en, input logic kv, input logic [3:0] kc);
      m_valid = 1'b0;
      if (r || !en) begin
         m_phase = 0; q.delete(); idle = 0;
      end else if (m_phase != 1) begin
         m_phase = 1; q.delete(); idle = 0;
      end else if (kv && kc <= 4'd9) begin
         if (q.size() < 20) q.push_back(int'(kc));
         idle = 0;
      end else if (kv && kc == 4'hA) begin
         emit(pack_q());
      end else if (kv && kc == 4'hB) begin
         if (q.size() == 0) emit(EXITP);
         else begin q.delete(); idle = 0; end
      end else if (q.size() > 0) begin
         if (idle == T - 1) emit(VOIDP);
         else idle++;
      end
      if (!m_valid) m_value = pack_q();
      m_count = q.size();
   endtask

   // Drive one cycle, advance the model, then settle past the edge.
   task automatic step(input logic r, input logic en, input logic kv, input logic [3:0] kc);
      rst = r; enable = en; key_valid = kv; key_code = kc;
      @(posedge clk);
      model_edge(r, en, kv, kc);
      #1;
      rst = 1'b0; key_valid = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 1, 0, 4'd0);
      step(1, 1, 1, 4'd5);
      vectors++;
      if (digitos_value !== ALL_F || digitos_valid !== 1'b0 || digit_count !== 5'd0) begin
         miscompares++;
         $display("FAIL reset: value=%h valid=%b count=%0d, required value=%h valid=0 count=0",
                  digitos_value, digitos_valid, digit_count, ALL_F);
      end
      step(0, 1, 0, 4'd0);   // OFF -> EMPTY
   endtask

   task automatic test_confirm();
      logic [3:0] keys [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'hA};
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, keys[i]);
         vectors++;
         if (digitos_value !== m_value || digitos_valid !== m_valid ||
             (!m_valid && digit_count !== 5'(m_count))) begin
            miscompares++;
            $display("FAIL confirm[%0d]: value=%h valid=%b count=%0d, required value=%h valid=%b count=%0d",
                     i, digitos_value, digitos_valid, digit_count, m_value, m_valid, m_count);
         end
      end
      vectors++;
      if (digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_1234 || digitos_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL confirm_pkt: value=%h valid=%b, required value=FFFFFFFFFFFFFFFF1234 valid=1",
                  digitos_value, digitos_valid);
      end
      step(0, 1, 0, 4'd0);
      vectors++;
      if (digitos_value !== ALL_F || digitos_valid !== 1'b0 || digit_count !== 5'd0) begin
         miscompares++;
         $display("FAIL confirm_after: value=%h valid=%b count=%0d, required all-F, 0, 0",
                  digitos_value, digitos_valid, digit_count);
      end
   endtask

   task automatic test_empty_keys();
      step(0, 1, 1, 4'hA);
      vectors++;
      if (digitos_value !== ALL_F || digitos_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_skip: value=%h valid=%b, required value=%h valid=1", digitos_value, digitos_valid, ALL_F);
      end
      step(0, 1, 0, 4'd0);
      step(0, 1, 1, 4'hB);
      vectors++;
      if (digitos_value !== EXITP || digitos_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_exit: value=%h valid=%b, required value=%h valid=1", digitos_value, digitos_valid, EXITP);
      end
      step(0, 1, 0, 4'd0);
   endtask

   task automatic test_timeout();
      int pulses;
      // Part 1: two digits then silence; the void packet arrives on idle cycle 16.
      step(0, 1, 1, 4'd7);
      step(0, 1, 1, 4'd8);
      pulses = 0;
      for (int c = 1; c <= T; c++) begin
         step(0, 1, 0, 4'd0);
         if (digitos_valid === 1'b1) pulses++;
         vectors++;
         if (digitos_value !== m_value || digitos_valid !== m_valid) begin
            miscompares++;
            $display("FAIL timeout[%0d]: value=%h valid=%b, required value=%h valid=%b",
                     c, digitos_value, digitos_valid, m_value, m_valid);
         end
      end
      vectors++;
      if (digitos_value !== VOIDP || digitos_valid !== 1'b1 || pulses != 1) begin
         miscompares++;
         $display("FAIL timeout_pkt: value=%h valid=%b pulses=%0d, required value=%h valid=1 pulses=1",
                  digitos_value, digitos_valid, pulses, VOIDP);
      end
      step(0, 1, 0, 4'd0);
      // Part 2: a key on idle cycle 15 restarts the count.
      step(0, 1, 1, 4'd7);
      step(0, 1, 1, 4'd8);
      for (int c = 1; c < T; c++) step(0, 1, 0, 4'd0);
      step(0, 1, 1, 4'd9);
      pulses = 0;
      for (int c = 1; c <= T; c++) begin
         step(0, 1, 0, 4'd0);
         if (c < T && digitos_valid === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 0 || digitos_valid !== 1'b1 || digitos_value !== VOIDP) begin
         miscompares++;
         $display("FAIL timeout_restart: early_pulses=%0d valid=%b value=%h, required 0, 1, %h",
                  pulses, digitos_valid, digitos_value, VOIDP);
      end
      step(0, 1, 0, 4'd0);
   endtask

   task automatic test_overflow();
      logic [3:0]  d [21];
      logic [79:0] want;
      for (int i = 0; i < 21; i++) begin
         d[i] = 4'($urandom_range(0, 9));
         step(0, 1, 1, d[i]);
      end
      vectors++;
      if (digit_count !== 5'd20 || digitos_value !== m_value) begin
         miscompares++;
         $display("FAIL overflow_count: count=%0d value=%h, required count=20 value=%h",
                  digit_count, digitos_value, m_value);
      end
      for (int i = 0; i < 20; i++) want[4*i +: 4] = d[19-i];
      step(0, 1, 1, 4'hA);
      vectors++;
      if (digitos_value !== want || digitos_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow_pkt: value=%h valid=%b, required value=%h valid=1", digitos_value, digitos_valid, want);
      end
      step(0, 1, 0, 4'd0);
   endtask

   task automatic test_clear();
      logic [3:0] keys [3] = '{4'd5, 4'd6, 4'hB};
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, keys[i]);
         if (digitos_valid === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 0 || digitos_value !== ALL_F || digit_count !== 5'd0) begin
         miscompares++;
         $display("FAIL clear: pulses=%0d value=%h count=%0d, required 0, %h, 0", pulses, digitos_value, digit_count, ALL_F);
      end
      step(0, 1, 1, 4'hB);
      vectors++;
      if (digitos_value !== EXITP || digitos_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_exit: value=%h valid=%b, required value=%h valid=1", digitos_value, digitos_valid, EXITP);
      end
      step(0, 1, 0, 4'd0);
   endtask

   task automatic test_enable_rst();
      // enable low mid-entry
      step(0, 1, 1, 4'd3);
      step(0, 1, 1, 4'd4);
      step(0, 0, 0, 4'd0);
      vectors++;
      if (digitos_value !== ALL_F || digitos_valid !== 1'b0 || digit_count !== 5'd0) begin
         miscompares++;
         $display("FAIL en_mid: value=%h valid=%b count=%0d, required all-F, 0, 0", digitos_value, digitos_valid, digit_count);
      end
      step(0, 1, 0, 4'd0);
      // confirm coinciding with enable low: no pulse
      step(0, 1, 1, 4'd5);
      step(0, 0, 1, 4'hA);
      vectors++;
      if (digitos_valid !== 1'b0 || digitos_value !== ALL_F) begin
         miscompares++;
         $display("FAIL en_send: valid=%b value=%h, required valid=0 value=%h", digitos_valid, digitos_value, ALL_F);
      end
      step(0, 1, 0, 4'd0);
      // rst mid-entry
      step(0, 1, 1, 4'd1);
      step(0, 1, 1, 4'd2);
      step(1, 1, 0, 4'd0);
      vectors++;
      if (digitos_value !== ALL_F || digitos_valid !== 1'b0 || digit_count !== 5'd0) begin
         miscompares++;
         $display("FAIL rst_mid: value=%h valid=%b count=%0d, required all-F, 0, 0", digitos_value, digitos_valid, digit_count);
      end
      // resumes in EMPTY after one OFF cycle: echo of a new key one cycle later
      step(0, 1, 0, 4'd0);
      step(0, 1, 1, 4'd6);
      vectors++;
      if (digitos_value !== {{19{4'hF}}, 4'd6} || digit_count !== 5'd1) begin
         miscompares++;
         $display("FAIL resume: value=%h count=%0d, required value=%h count=1",
                  digitos_value, digit_count, {{19{4'hF}}, 4'd6});
      end
      // enable dropped during the SEND cycle
      step(0, 1, 1, 4'hA);
      step(0, 0, 1, 4'd7);
      vectors++;
      if (digitos_value !== ALL_F || digitos_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL en_after_send: value=%h valid=%b, required all-F, 0", digitos_value, digitos_valid);
      end
      step(0, 1, 0, 4'd0);
   endtask

   task automatic test_random();
      int  kprob;
      logic r, en, kv;
      logic [3:0] kc;
      for (int b = 0; b < 30; b++) begin
         kprob = ($urandom_range(0, 2) == 0) ? 4 : 45;
         for (int c = 0; c < 25; c++) begin
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 59) != 0);
            kv = ($urandom_range(0, 99) < kprob);
            kc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step(r, en, kv, kc);
            vectors++;
            if (digitos_value !== m_value || digitos_valid !== m_valid ||
                (!m_valid && digit_count !== 5'(m_count))) begin
               miscompares++;
               $display("FAIL random[%0d.%0d]: value=%h valid=%b count=%0d, required value=%h valid=%b count=%0d",
                        b, c, digitos_value, digitos_valid, digit_count, m_value, m_valid, m_count);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_confirm();
      test_empty_keys();
      test_timeout();
      test_overflow();
      test_clear();
      test_enable_rst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
